// File: rtl/voltmeter_pkg.sv
// Shared constants and scan FSM encoding for the voltmeter datapath.
// Channel count, result width and scan timing defaults.
package voltmeter_pkg;
   localparam int NCH = 13;
   localparam int DW = 16;
   localparam int CHW = 4;
   localparam int SCAN_PERIOD_DEF = 1_000_000;
   localparam int TIMEOUT_DEF = 200_000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ADVANCE
   } scan_state_t;
endpackage

// File: rtl/scan_period_timer.sv
// Free-running scan period counter with a single-entry tick latch.
// Counter is held at zero while scanning is disabled.
module scan_period_timer
   import voltmeter_pkg::*;
#(
   parameter int PERIOD = SCAN_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic tick_pending
);

   localparam int CW = $clog2(PERIOD);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = enable && (cnt == CW'(PERIOD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         tick_pending <= 1'b0;
      end else begin
         if (!enable || wrap)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         // a fresh wrap outranks the consumer's clear
         if (wrap)
            tick_pending <= 1'b1;
         else if (clear)
            tick_pending <= 1'b0;
      end
   end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin conversion scheduler over all measurement channels.
// Owns the shared engine, result bank, stale flags and timeouts.
module adc_scan_sequencer
   import voltmeter_pkg::*;
#(
   parameter int SCAN_PERIOD = SCAN_PERIOD_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   output logic              conv_start,
   output logic [CHW-1:0]    conv_ch,
   input  logic              conv_done,
   input  logic [DW-1:0]     conv_data,
   output logic [NCH*DW-1:0] ch_data,
   output logic [NCH-1:0]    ch_stale,
   output logic              scan_done,
   output logic              busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   scan_state_t    state, state_nx;
   logic [CHW-1:0] ch_nx;
   logic [TW-1:0]  tcnt;
   logic           tick_pending;
   logic           tick_clr;
   logic           start_nx;
   logic           sdone_nx;
   logic           store;
   logic           expire;

   scan_period_timer #(
      .PERIOD(SCAN_PERIOD)
   ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .clear        (tick_clr),
      .tick_pending (tick_pending)
   );

   always_comb begin
      state_nx = state;
      ch_nx = conv_ch;
      tick_clr = 1'b0;
      start_nx = 1'b0;
      sdone_nx = 1'b0;
      store = 1'b0;
      expire = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable && tick_pending) begin
               tick_clr = 1'b1;
               ch_nx = '0;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            start_nx = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            if (conv_done) begin
               store = 1'b1;
               state_nx = ADVANCE;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               expire = 1'b1;
               state_nx = ADVANCE;
            end
         end
         ADVANCE: begin
            if (conv_ch == CHW'(NCH - 1)) begin
               sdone_nx = 1'b1;
               state_nx = IDLE;
            end else if (!enable) begin
               state_nx = IDLE;
            end else begin
               ch_nx = conv_ch + 1'b1;
               state_nx = ISSUE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         conv_ch <= '0;
         conv_start <= 1'b0;
         scan_done <= 1'b0;
         busy <= 1'b0;
         tcnt <= '0;
         ch_data <= '0;
         ch_stale <= '1;
      end else begin
         state <= state_nx;
         conv_ch <= ch_nx;
         conv_start <= start_nx;
         scan_done <= sdone_nx;
         busy <= (state_nx != IDLE);
         // zero in ISSUE so the count equals cycles since conv_start
         if (state == ISSUE)
            tcnt <= '0;
         else if (state == WAIT)
            tcnt <= tcnt + 1'b1;
         for (int k = 0; k < NCH; k++) begin
            if (conv_ch == CHW'(k)) begin
               if (store) begin
                  ch_data[k*DW +: DW] <= conv_data;
                  ch_stale[k] <= 1'b0;
               end else if (expire) begin
                  ch_stale[k] <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench: normal, timeout, coincidence, abort, reset scans
// on a slow-period unit plus a back-to-back overrun unit.
module tb_adc_scan_sequencer;
   import voltmeter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst2_n = 1'b0;
   logic enable = 1'b0;
   logic enable2 = 1'b0;

   logic              conv_start, scan_done, busy;
   logic [CHW-1:0]    conv_ch;
   logic              conv_done = 1'b0;
   logic [DW-1:0]     conv_data = '0;
   logic [NCH*DW-1:0] ch_data;
   logic [NCH-1:0]    ch_stale;

   logic              conv_start2, scan_done2, busy2;
   logic [CHW-1:0]    conv_ch2;
   logic              conv_done2 = 1'b0;
   logic [DW-1:0]     conv_data2 = '0;
   logic [NCH*DW-1:0] ch_data2;
   logic [NCH-1:0]    ch_stale2;

   always #5 clk = ~clk;

   adc_scan_sequencer #(
      .SCAN_PERIOD(100),
      .TIMEOUT(20)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .conv_start (conv_start),
      .conv_ch    (conv_ch),
      .conv_done  (conv_done),
      .conv_data  (conv_data),
      .ch_data    (ch_data),
      .ch_stale   (ch_stale),
      .scan_done  (scan_done),
      .busy       (busy)
   );

   adc_scan_sequencer #(
      .SCAN_PERIOD(30),
      .TIMEOUT(20)
   ) u_ovr (
      .clk        (clk),
      .rst_n      (rst2_n),
      .enable     (enable2),
      .conv_start (conv_start2),
      .conv_ch    (conv_ch2),
      .conv_done  (conv_done2),
      .conv_data  (conv_data2),
      .ch_data    (ch_data2),
      .ch_stale   (ch_stale2),
      .scan_done  (scan_done2),
      .busy       (busy2)
   );

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;

   int          dly[NCH];
   logic [DW-1:0] resp[NCH];
   int          st_cyc[NCH];
   int          ch_seq[$];
   int          nstart = 0;
   int          scan_cnt = 0;
   int          gap = 0;
   int          stale4_cyc = -1;
   bit          in_scan = 1'b0;
   logic        prev4 = 1'b1;
   int          pend = 0;
   logic [DW-1:0] pdata = '0;

   int          pend2 = 0;
   int          n2 = 0;
   int          scans2 = 0;
   int          last_sd2 = 0;
   int          ovl = 0;
   int          bad2 = 0;
   int          gap2 = 0;
   bit          out2 = 1'b0;

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] slot(input int k);
      return ch_data[k*DW +: DW];
   endfunction

   task automatic wait_scans(input int n, input int lim);
      for (int i = 0; i < lim && scan_cnt < n; i++) begin
         @(posedge clk);
         #2;
      end
      chk("scan_wait", scan_cnt, n);
   endtask

   // engine models and monitors, sampled 1 time unit after each edge
   always @(posedge clk) begin
      cyc++;
      #1;
      conv_done = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            conv_done = 1'b1;
            conv_data = pdata;
         end
      end
      if (conv_start) begin
         st_cyc[conv_ch] = cyc;
         nstart++;
         ch_seq.push_back(int'(conv_ch));
         pend = dly[conv_ch];
         pdata = resp[conv_ch];
         if (conv_ch == 0)
            in_scan = 1'b1;
      end
      if (scan_done) begin
         scan_cnt++;
         in_scan = 1'b0;
      end
      if (in_scan && !busy)
         gap++;
      if (ch_stale[4] && !prev4)
         stale4_cyc = cyc;
      prev4 = ch_stale[4];

      conv_done2 = 1'b0;
      if (pend2 > 0) begin
         pend2--;
         if (pend2 == 0) begin
            conv_done2 = 1'b1;
            conv_data2 = 16'h0100 + DW'(conv_ch2);
            out2 = 1'b0;
         end
      end
      if (conv_start2) begin
         if (out2)
            ovl++;
         if (n2 == 0 && scans2 > 0 && (cyc - last_sd2) != 2)
            gap2++;
         out2 = 1'b1;
         n2++;
         pend2 = 5;
      end
      if (scan_done2) begin
         if (n2 != NCH)
            bad2++;
         n2 = 0;
         scans2++;
         last_sd2 = cyc;
      end
   end

   initial begin
      int t0;
      int n7;
      for (int k = 0; k < NCH; k++) begin
         dly[k] = 5;
         resp[k] = 16'h0100 + DW'(k);
         st_cyc[k] = -1;
      end
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      rst2_n = 1'b1;
      @(posedge clk);
      #2;
      chk("rst_conv_start", conv_start, 0);
      chk("rst_conv_ch", conv_ch, 0);
      chk("rst_ch_data", ch_data, 0);
      chk("rst_ch_stale", ch_stale, 13'h1fff);
      chk("rst_scan_done", scan_done, 0);
      chk("rst_busy", busy, 0);

      enable = 1'b1;
      enable2 = 1'b1;
      ch_seq.delete();
      wait_scans(1, 400);
      chk("seq_len", ch_seq.size(), NCH);
      for (int k = 0; k < NCH && k < ch_seq.size(); k++)
         chk($sformatf("seq_%0d", k), ch_seq[k], k);
      for (int k = 0; k < NCH; k++)
         chk($sformatf("slot_%0d", k), slot(k), 16'h0100 + k);
      chk("stale_scan1", ch_stale, 0);

      resp[4] = 16'h1234;
      wait_scans(2, 300);
      chk("preload4", slot(4), 16'h1234);

      dly[4] = 0;
      wait_scans(3, 300);
      chk("tmo_delay", stale4_cyc - st_cyc[4], 20);
      chk("tmo_next", st_cyc[5] - st_cyc[4], 22);
      chk("tmo_keep4", slot(4), 16'h1234);
      chk("tmo_stale", ch_stale, 13'h0010);

      dly[4] = 19;
      resp[4] = 16'h0777;
      wait_scans(4, 300);
      chk("coin_slot4", slot(4), 16'h0777);
      chk("coin_stale", ch_stale, 0);
      chk("coin_next", st_cyc[5] - st_cyc[4], 22);
      chk("busy_gap", gap, 0);

      dly[4] = 5;
      dly[7] = 10;
      resp[7] = 16'h0707;
      t0 = cyc;
      for (int i = 0; i < 300 && st_cyc[7] <= t0; i++) begin
         @(posedge clk);
         #2;
      end
      chk("abort_seen7", st_cyc[7] > t0, 1);
      n7 = nstart;
      repeat (3) @(posedge clk);
      #2;
      enable = 1'b0;
      repeat (30) @(posedge clk);
      #2;
      chk("abort_starts", nstart, n7);
      chk("abort_nodone", scan_cnt, 4);
      chk("abort_busy", busy, 0);
      chk("abort_slot7", slot(7), 16'h0707);
      chk("abort_stale7", ch_stale[7], 0);
      chk("abort_cnt", dut.u_timer.cnt, 0);

      dly[7] = 5;
      dly[2] = 9;
      resp[2] = 16'hbeef;
      enable = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 300 && st_cyc[2] <= t0; i++) begin
         @(posedge clk);
         #2;
      end
      chk("rst_seen2", st_cyc[2] > t0, 1);
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      enable = 1'b0;
      #1;
      chk("inrst_busy", busy, 0);
      chk("inrst_stale", ch_stale, 13'h1fff);
      chk("inrst_data", ch_data, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("post_conv_start", conv_start, 0);
      chk("post_conv_ch", conv_ch, 0);
      chk("post_scan_done", scan_done, 0);
      chk("post_busy", busy, 0);
      chk("post_stale", ch_stale, 13'h1fff);
      chk("post_data", ch_data, 0);

      chk("ovr_overlap", ovl, 0);
      chk("ovr_per_scan", bad2, 0);
      chk("ovr_gap", gap2, 0);
      chk("ovr_scans", scans2 >= 3, 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
